// File: rtl/systolic_result_drain.sv
// Captures a systolic array's accumulator matrix on the done_i rising edge and streams it
// out as a valid/ready sequence of OUT_W samples, row-major or column-major.
module systolic_result_drain #(
    parameter int ROW_NUM = 4,
    parameter int COL_NUM = 4,
    parameter int ACC_W   = 20,
    parameter int OUT_W   = 16,
    parameter int SAT     = 1,
    localparam int RW     = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1,
    localparam int CW     = (COL_NUM > 1) ? $clog2(COL_NUM) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             done_i,
    input  logic [ROW_NUM*COL_NUM*ACC_W-1:0] acc_flat_i,
    input  logic                             col_major_i,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [OUT_W-1:0]                 m_data,
    output logic [RW-1:0]                    m_row,
    output logic [CW-1:0]                    m_col,
    output logic                             m_last,
    output logic                             busy,
    output logic                             drain_done,
    output logic                             overrun
);

    localparam int N  = ROW_NUM * COL_NUM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(ROW_NUM - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(COL_NUM - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic          done_q_reg;
    logic [IW-1:0] idx_reg, idx_next;
    logic [RW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic          col_major_reg, col_major_next;
    logic          drain_done_reg, drain_done_next;
    logic          overrun_reg, overrun_next;

    logic [ACC_W-1:0] buf_reg [ROW_NUM][COL_NUM];

    logic capture;
    logic load;
    logic handshake;
    logic at_last;

    assign busy      = (state_reg == STREAM);
    assign capture   = done_i & ~done_q_reg;
    assign load      = capture & ~busy;
    assign handshake = busy & m_ready;
    assign at_last   = busy && (idx_reg == IDX_LAST);

    // Row/column counters walk the matrix directly so no divider is needed for the order mapping.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        col_major_next  = col_major_reg;
        drain_done_next = handshake & at_last;
        overrun_next    = overrun_reg | (capture & busy);
        if (load) begin
            state_next     = STREAM;
            idx_next       = '0;
            row_next       = '0;
            col_next       = '0;
            col_major_next = col_major_i;
        end else if (handshake) begin
            if (at_last) begin
                state_next = IDLE;
                idx_next   = '0;
                row_next   = '0;
                col_next   = '0;
            end else begin
                idx_next = idx_reg + 1'b1;
                if (col_major_reg) begin
                    if (row_reg == ROW_MAX) begin
                        row_next = '0;
                        col_next = col_reg + 1'b1;
                    end else begin
                        row_next = row_reg + 1'b1;
                    end
                end else begin
                    if (col_reg == COL_MAX) begin
                        col_next = '0;
                        row_next = row_reg + 1'b1;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            done_q_reg     <= 1'b0;
            idx_reg        <= '0;
            row_reg        <= '0;
            col_reg        <= '0;
            col_major_reg  <= 1'b0;
            drain_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            done_q_reg     <= done_i;
            idx_reg        <= idx_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            col_major_reg  <= col_major_next;
            drain_done_reg <= drain_done_next;
            overrun_reg    <= overrun_next;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROW_NUM; gi++) begin : g_row
            for (gj = 0; gj < COL_NUM; gj++) begin : g_col
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        buf_reg[gi][gj] <= '0;
                    end else if (load) begin
                        buf_reg[gi][gj] <= acc_flat_i[(gi*COL_NUM+gj)*ACC_W +: ACC_W];
                    end
                end
            end
        end
    endgenerate

    logic [ACC_W-1:0] sel_acc;
    logic [OUT_W-1:0] conv;

    assign sel_acc = buf_reg[row_reg][col_reg];

    generate
        if (SAT != 0) begin : g_sat
            // In range exactly when every bit from the output sign bit upward agrees.
            logic [ACC_W-OUT_W:0] upper;
            logic                 in_range;
            assign upper    = sel_acc[ACC_W-1:OUT_W-1];
            assign in_range = (&upper) | ~(|upper);
            always_comb begin
                conv = sel_acc[OUT_W-1:0];
                if (!in_range) begin
                    conv = sel_acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_trunc
            assign conv = sel_acc[OUT_W-1:0];
        end
    endgenerate

    assign m_valid    = busy;
    assign m_data     = busy ? conv : '0;
    assign m_row      = busy ? row_reg : '0;
    assign m_col      = busy ? col_reg : '0;
    assign m_last     = at_last;
    assign drain_done = drain_done_reg;
    assign overrun    = overrun_reg;

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter ROW_NUM, default 4, meaning result matrix rows.
REQ-002 SHALL have parameter COL_NUM, default 4, meaning result matrix columns.
REQ-003 SHALL have parameter ACC_W, default 20, meaning signed accumulator width per PE.
REQ-004 SHALL have parameter OUT_W, default 16, meaning output sample width (OUT_W <= ACC_W).
REQ-005 SHALL have parameter SAT, default 1, meaning 1 = saturate to OUT_W, 0 = truncate.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port done_i, input, 1, compute-complete level from the array controller.
REQ-009 SHALL have port acc_flat_i, input, ROW_NUM*COL_NUM*ACC_W, PE accumulators; element (r,c) at bits [(r*COL_NUM+c)*ACC_W +: ACC_W].
REQ-010 SHALL have port col_major_i, input, 1, stream order select, sampled at capture.
REQ-011 SHALL have port m_valid, output, 1, output sample valid.
REQ-012 SHALL have port m_ready, input, 1, downstream ready.
REQ-013 SHALL have port m_data, output, OUT_W, converted result sample.
REQ-014 SHALL have port m_row, output, clog2(ROW_NUM), row index of m_data.
REQ-015 SHALL have port m_col, output, clog2(COL_NUM), column index of m_data.
REQ-016 SHALL have port m_last, output, 1, marks final sample of the matrix.
REQ-017 SHALL have port busy, output, 1, high while a captured matrix is not fully drained.
REQ-018 SHALL have port drain_done, output, 1, single-cycle pulse after final handshake.
REQ-019 SHALL have port overrun, output, 1, sticky flag: new done edge arrived while busy.

Function
REQ-020 SHALL implement FSM states IDLE and STREAM; busy = (state == STREAM).
REQ-021 SHALL register done_i into done_q; capture event = done_i & ~done_q.
REQ-022 In IDLE on a capture event, SHALL latch all acc_flat_i elements into an internal ROW_NUM*COL_NUM buffer, latch col_major_i, clear index counter to 0, and enter STREAM at that edge.
REQ-023 m_valid SHALL equal busy; first m_valid is the cycle after the capture edge (latency 1).
REQ-024 A handshake SHALL occur on a rising edge with m_valid & m_ready; index advances by 1 per handshake only.
REQ-025 While m_valid & ~m_ready, m_data, m_row, m_col, m_last SHALL hold stable.
REQ-026 Row-major (col_major=0): index k -> row k/COL_NUM, col k%COL_NUM; col-major: row k%ROW_NUM, col k/ROW_NUM.
REQ-027 m_last SHALL be high exactly when index == ROW_NUM*COL_NUM-1 and m_valid high.
REQ-028 On handshake with m_last, SHALL return to IDLE and assert drain_done for exactly the next cycle.
REQ-029 SAT=1: signed value > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; < -2^(OUT_W-1) -> -2^(OUT_W-1); else sign-preserved low OUT_W bits.
REQ-030 SAT=0: m_data SHALL be acc[OUT_W-1:0].
REQ-031 m_data/m_row/m_col SHALL be 0 when m_valid low.
REQ-032 Capture event while in STREAM SHALL be ignored (buffer unchanged) and set overrun to 1.
REQ-033 Capture event coincident with the final handshake SHALL be treated as overrun (not captured).
REQ-034 acc_flat_i changes after capture SHALL NOT affect streamed data.
REQ-035 done_i held high continuously SHALL produce only one capture.

Reset
REQ-036 On rst_n low, SHALL immediately force IDLE, done_q=0, index=0, buffer=0, m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, busy=0, drain_done=0, overrun=0.
REQ-037 Reset mid-stream SHALL discard remaining samples; no drain_done is issued.
REQ-038 done_i high on first edge after reset release SHALL count as a capture event.

Verification
REQ-039 acc (r,c)=r*4+c, row-major, m_ready=1 -> 16 samples 0..15 on consecutive cycles, m_last on 16th, drain_done next cycle.
REQ-040 Same data, col_major_i=1 -> order 0,4,8,12,1,5,...,15 with matching m_row/m_col.
REQ-041 acc(0,0)=40000, acc(0,1)=-40000, acc(0,2)=-5, SAT=1 -> 32767, -32768, -5 (0xFFFB); SAT=0 -> 0x9C40, 0x63C0, 0xFFFB.
REQ-042 m_ready toggled pseudo-randomly -> outputs held stable during stalls, exactly 16 handshakes, no duplicates/drops.
REQ-043 done_i pulsed low-high during STREAM -> overrun=1 sticky, stream completes with original data.
REQ-044 rst_n asserted after 5th handshake -> all outputs 0 at once; new done_i edge after release restarts from index 0.
